pipeline_run_ctrl: RTL and testbench

Synthesizable run controller that sequences one program run of the `pipeline` core. It replaces fixed reset delays and fixed stop times with parametrised cycle counts and a verdict. It holds the core in reset for a programmable number of cycles, drives the switch inputs, and runs the core under a cycle budget. It then declares pass, fail, timeout or hang from a signature the program writes to the red LEDs. It sits beside the core in both simulation top-levels and FPGA builds, and its verdict drives the bench's end-of-run.

---
 rtl/pipeline_run_pkg.sv | 16 +
 rtl/run_sat_cnt.sv | 25 ++
 rtl/pipeline_run_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_run_pkg.sv
// Shared types and default signatures for the pipeline run controller.
package pipeline_run_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4,
        HANG    = 3'd5
    } run_state_e;

    localparam logic [31:0] PASS_SIG = 32'h0000_600D;
    localparam logic [31:0] FAIL_SIG = 32'h0000_0BAD;

endpackage

// File: rtl/run_sat_cnt.sv
// Saturating up-counter. Clear wins over enable; clear together with enable
// restarts the count at 1 so the current cycle is counted.
module run_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= en_i ? ONE : '0;
        end else if (en_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + ONE;
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller for the pipeline core: reset hold, cycle budget and verdict
// from the LED signature. Define RUN_CTRL_STALL_DETECT_EN to enable PC hang detection.
//
// Handshake: restart_i is a single-cycle request with no ready; it is always
// accepted at the next edge. done_o and the verdict flags are sticky levels
// that stay valid until restart_i or rst_ni.
module pipeline_run_ctrl #(
    parameter int unsigned RST_CYCLES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned CNT_W          = 32,
    parameter logic [31:0] PASS_SIG       = pipeline_run_pkg::PASS_SIG,
    parameter logic [31:0] FAIL_SIG       = pipeline_run_pkg::FAIL_SIG,
    parameter logic [31:0] SW_INIT        = 32'h0,
    parameter int unsigned STALL_CYCLES   = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        restart_i,
    input  logic [31:0]                 io_ledr_i,
    input  logic [31:0]                 pc_debug_i,
    output logic                        dut_rst_no,
    output logic [31:0]                 io_sw_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic                        fail_o,
    output logic                        timeout_o,
    output logic                        hang_o,
    output logic [CNT_W-1:0]            cycle_cnt_o,
    output pipeline_run_pkg::run_state_e state_o
);

    import pipeline_run_pkg::*;

    localparam logic [CNT_W-1:0] RST_M1     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

    run_state_e       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic             last_fail;

    logic in_run, sig_pass, sig_fail, sig_hit, sig_switch, match_done;
    logic pass_hit, fail_hit, hang_hit, timeout_hit, hold_done;

    assign in_run     = (state == RUN);
    assign sig_pass   = (io_ledr_i == PASS_SIG);
    assign sig_fail   = (io_ledr_i == FAIL_SIG);
    assign sig_hit    = sig_pass || sig_fail;
    assign sig_switch = (match_cnt != '0) && (sig_fail != last_fail);

    // This sample is the STABLE_CYCLES-th consecutive match of one signature.
    assign match_done = ((match_cnt == '0) || sig_switch) ? (STABLE_CYCLES == 1)
                                                          : (match_cnt >= STABLE_M1);
    assign pass_hit    = in_run && sig_pass && match_done;
    assign fail_hit    = in_run && sig_fail && match_done;
    assign timeout_hit = in_run && (cycle_cnt_o == TIMEOUT_M1);
    assign hold_done   = (state == HOLD) && (hold_cnt == RST_M1);

    run_sat_cnt #(.W(CNT_W)) u_hold_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (restart_i),
        .en_i  ((state == HOLD) && !restart_i),
        .cnt_o (hold_cnt)
    );

    run_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (restart_i),
        .en_i  (in_run && !restart_i),
        .cnt_o (cycle_cnt_o)
    );

    run_sat_cnt #(.W(CNT_W)) u_match_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (restart_i || (in_run && (!sig_hit || sig_switch))),
        .en_i  (in_run && sig_hit && !restart_i),
        .cnt_o (match_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_fail <= 1'b0;
        end else if (in_run && sig_hit) begin
            last_fail <= sig_fail;
        end
    end

`ifdef RUN_CTRL_STALL_DETECT_EN
    localparam logic [CNT_W-1:0] STALL_M1 = CNT_W'(STALL_CYCLES - 1);

    logic [31:0]      prev_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             pc_same;

    // RUN cycle 0 has no previous RUN-cycle PC to compare against.
    assign pc_same  = (cycle_cnt_o != '0) && (pc_debug_i == prev_pc);
    assign hang_hit = in_run && pc_same && (stall_cnt >= STALL_M1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_pc <= '0;
        end else if (in_run) begin
            prev_pc <= pc_debug_i;
        end
    end

    run_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (restart_i || (in_run && !pc_same)),
        .en_i  (in_run && pc_same && !restart_i),
        .cnt_o (stall_cnt)
    );
`else
    logic unused_stall;
    assign unused_stall = ^{pc_debug_i, 32'(STALL_CYCLES)};
    assign hang_hit     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= HOLD;
            dut_rst_no <= 1'b0;
            io_sw_o    <= SW_INIT;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            hang_o     <= 1'b0;
        end else begin
            io_sw_o <= SW_INIT;
            if (restart_i) begin
                state      <= HOLD;
                dut_rst_no <= 1'b0;
                done_o     <= 1'b0;
                pass_o     <= 1'b0;
                fail_o     <= 1'b0;
                timeout_o  <= 1'b0;
                hang_o     <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_done) begin
                            state      <= RUN;
                            dut_rst_no <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (fail_hit) begin
                            state  <= FAIL;
                            done_o <= 1'b1;
                            fail_o <= 1'b1;
                        end else if (pass_hit) begin
                            state  <= PASS;
                            done_o <= 1'b1;
                            pass_o <= 1'b1;
                        end else if (hang_hit) begin
                            state  <= HANG;
                            done_o <= 1'b1;
                            hang_o <= 1'b1;
                        end else if (timeout_hit) begin
                            state     <= TIMEOUT;
                            done_o    <= 1'b1;
                            timeout_o <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: directed and random LED/PC programs
// checked against a sample-sequence reference model. Honours RUN_CTRL_STALL_DETECT_EN.
module tb_pipeline_run_ctrl;

    localparam int unsigned RST_CYCLES     = 5;
    localparam int unsigned TIMEOUT_CYCLES = 1000;
    localparam int unsigned STABLE_CYCLES  = 4;
    localparam int unsigned CNT_W          = 32;
    localparam logic [31:0] PASS_SIG       = 32'h0000_600D;
    localparam logic [31:0] FAIL_SIG       = 32'h0000_0BAD;
    localparam logic [31:0] SW_INIT        = 32'h0;
    localparam int unsigned STALL_CYCLES   = 64;

    localparam int V_PASS = 1, V_FAIL = 2, V_TO = 3, V_HANG = 4;

    logic                         clk = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         restart_i = 1'b0;
    logic [31:0]                  io_ledr_i = '0;
    logic [31:0]                  pc_debug_i = '0;
    logic                         dut_rst_no;
    logic [31:0]                  io_sw_o;
    logic                         done_o, pass_o, fail_o, timeout_o, hang_o;
    logic [CNT_W-1:0]             cycle_cnt_o;
    pipeline_run_pkg::run_state_e state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] seq_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] exp_q[$];

    pipeline_run_ctrl #(
        .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W),
        .PASS_SIG(PASS_SIG), .FAIL_SIG(FAIL_SIG),
        .SW_INIT(SW_INIT), .STALL_CYCLES(STALL_CYCLES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .restart_i(restart_i),
        .io_ledr_i(io_ledr_i), .pc_debug_i(pc_debug_i),
        .dut_rst_no(dut_rst_no), .io_sw_o(io_sw_o), .done_o(done_o),
        .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o), .hang_o(hang_o),
        .cycle_cnt_o(cycle_cnt_o), .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] noise();
        logic [31:0] v;
        v = $urandom;
        if (v == PASS_SIG || v == FAIL_SIG) v = 32'h1;
        return v;
    endfunction

    // Reference: scan RUN-cycle samples for the first deciding cycle.
    task automatic predict();
        int mrun, srun, d, v;
        mrun = 0; srun = 0;
        d = TIMEOUT_CYCLES - 1; v = V_TO;
        for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
            if (seq_q[k] != PASS_SIG && seq_q[k] != FAIL_SIG) mrun = 0;
            else if (k > 0 && seq_q[k] == seq_q[k-1]) mrun++;
            else mrun = 1;
            if (k > 0 && pc_q[k] == pc_q[k-1]) srun++;
            else srun = 0;
            if (mrun >= STABLE_CYCLES && seq_q[k] == FAIL_SIG) begin v = V_FAIL; d = k; break; end
            if (mrun >= STABLE_CYCLES) begin v = V_PASS; d = k; break; end
`ifdef RUN_CTRL_STALL_DETECT_EN
            if (srun >= STALL_CYCLES) begin v = V_HANG; d = k; break; end
`endif
        end
        exp_q.push_back(32'(v));
        exp_q.push_back(32'(d));
    endtask

    task automatic wait_run(input string tag);
        int edges, bad;
        edges = 0; bad = 0;
        while (dut_rst_no !== 1'b1 && edges < 20) begin
            if (done_o || pass_o || fail_o || timeout_o || hang_o || cycle_cnt_o != '0 ||
                io_sw_o !== SW_INIT || state_o !== pipeline_run_pkg::HOLD) bad = 1;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_hold_edges"}, 64'(edges), 64'(RST_CYCLES));
        check({tag, "_hold_outputs"}, 64'(bad), 64'd0);
    endtask

    task automatic do_restart(input string tag);
        restart_i = 1'b1;
        @(posedge clk); #1;
        restart_i = 1'b0;
        check({tag, "_clr_flags"}, {59'd0, done_o, pass_o, fail_o, timeout_o, hang_o}, 64'd0);
        check({tag, "_clr_rst"}, 64'(dut_rst_no), 64'd0);
        check({tag, "_clr_cnt"}, 64'(cycle_cnt_o), 64'd0);
        wait_run(tag);
    endtask

    task automatic run_and_check(input string tag, output int d_out);
        int v, d, early;
        pipeline_run_pkg::run_state_e exp_st;
        v = int'(exp_q.pop_front());
        d = int'(exp_q.pop_front());
        early = 0;
        for (int k = 0; k <= d; k++) begin
            io_ledr_i  = seq_q[k];
            pc_debug_i = pc_q[k];
            @(posedge clk); #1;
            if (k < d && done_o !== 1'b0) early = 1;
        end
        case (v)
            V_PASS:  exp_st = pipeline_run_pkg::PASS;
            V_FAIL:  exp_st = pipeline_run_pkg::FAIL;
            V_HANG:  exp_st = pipeline_run_pkg::HANG;
            default: exp_st = pipeline_run_pkg::TIMEOUT;
        endcase
        check({tag, "_early_done"}, 64'(early), 64'd0);
        check({tag, "_verdict"}, {59'd0, done_o, pass_o, fail_o, timeout_o, hang_o},
              {59'd0, 1'b1, v == V_PASS, v == V_FAIL, v == V_TO, v == V_HANG});
        check({tag, "_state"}, 64'(state_o), 64'(exp_st));
        check({tag, "_cycle_cnt"}, 64'(cycle_cnt_o), 64'(d + 1));
        for (int j = 0; j < 4; j++) begin
            io_ledr_i  = (j % 2 == 0) ? noise() : (v == V_PASS ? FAIL_SIG : PASS_SIG);
            pc_debug_i = $urandom;
            @(posedge clk); #1;
        end
        check({tag, "_frozen_cnt"}, 64'(cycle_cnt_o), 64'(d + 1));
        check({tag, "_sticky"}, {62'd0, done_o, dut_rst_no}, 64'd3);
        d_out = d;
    endtask

    task automatic fill_noise_pc();
        pc_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++)
            pc_q.push_back((k == 0 || $urandom_range(0, 7) != 0) ? $urandom : pc_q[k-1]);
    endtask

    initial begin
        int d;
        int kind, len;

        // reset values and hold length after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {57'd0, dut_rst_no, done_o, pass_o, fail_o, timeout_o, hang_o, 1'b0}, 64'd0);
        check("rst_sw", 64'(io_sw_o), 64'(SW_INIT));
        check("rst_cnt", 64'(cycle_cnt_o), 64'd0);
        check("rst_state", 64'(state_o), 64'(pipeline_run_pkg::HOLD));
        rst_ni = 1'b1;
        wait_run("release");

        // PASS_SIG from RUN cycle 300
        seq_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++) seq_q.push_back(k < 300 ? noise() : PASS_SIG);
        fill_noise_pc();
        predict();
        run_and_check("pass300", d);
        check("pass300_cnt_spec", 64'(cycle_cnt_o), 64'd304);
        do_restart("restart_pass");

        // PASS x3, zero, then FAIL held
        seq_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++)
            seq_q.push_back(k < 50 ? noise() : k < 53 ? PASS_SIG : k == 53 ? 32'h0 : FAIL_SIG);
        fill_noise_pc();
        predict();
        run_and_check("pass3_fail", d);
        check("pass3_fail_cnt_spec", 64'(cycle_cnt_o), 64'd58);
        do_restart("restart_fail");

        // LEDs at zero: timeout
        seq_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++) seq_q.push_back(32'h0);
        fill_noise_pc();
        predict();
        run_and_check("timeout", d);
        check("timeout_cnt_spec", 64'(cycle_cnt_o), 64'(TIMEOUT_CYCLES));
        do_restart("restart_to");

        // FAIL qualifies on the timeout edge
        seq_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++)
            seq_q.push_back(k < TIMEOUT_CYCLES - STABLE_CYCLES ? noise() : FAIL_SIG);
        fill_noise_pc();
        predict();
        run_and_check("fail_vs_to", d);
        check("fail_vs_to_flags", {62'd0, fail_o, timeout_o}, 64'd2);
        do_restart("restart_fto");

        // PC constant from RUN cycle 10
        seq_q.delete();
        pc_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
            seq_q.push_back(noise());
            pc_q.push_back(k < 10 ? 32'(k * 4) : 32'd36);
        end
        predict();
        run_and_check("stall", d);
`ifdef RUN_CTRL_STALL_DETECT_EN
        check("stall_cnt_spec", 64'(cycle_cnt_o), 64'd74);
`else
        check("stall_no_hang", 64'(hang_o), 64'd0);
`endif
        do_restart("restart_stall");

        // randomized signature programs
        for (int r = 0; r < 6; r++) begin
            seq_q.delete();
            while (seq_q.size() < TIMEOUT_CYCLES) begin
                kind = $urandom_range(0, 2);
                len  = $urandom_range(1, 5);
                for (int j = 0; j < len; j++)
                    seq_q.push_back(kind == 0 ? noise() : kind == 1 ? PASS_SIG : FAIL_SIG);
            end
            while (seq_q.size() > TIMEOUT_CYCLES) void'(seq_q.pop_back());
            fill_noise_pc();
            predict();
            run_and_check($sformatf("rand%0d", r), d);
            do_restart($sformatf("restart_rand%0d", r));
        end

        // asynchronous reset mid-run, then a fresh run
        for (int k = 0; k < 20; k++) begin
            io_ledr_i = noise();
            @(posedge clk); #1;
        end
        #3 rst_ni = 1'b0;
        #1;
        check("arst_outputs", {58'd0, dut_rst_no, done_o, pass_o, fail_o, timeout_o, hang_o}, 64'd0);
        check("arst_cnt", 64'(cycle_cnt_o), 64'd0);
        check("arst_state", 64'(state_o), 64'(pipeline_run_pkg::HOLD));
        @(posedge clk); #1;
        rst_ni = 1'b1;
        wait_run("arst_release");
        seq_q.delete();
        for (int k = 0; k < TIMEOUT_CYCLES; k++) seq_q.push_back(PASS_SIG);
        fill_noise_pc();
        predict();
        run_and_check("arst_pass", d);
        check("arst_pass_cnt", 64'(cycle_cnt_o), 64'(STABLE_CYCLES));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
